sfp_norm_seq: RTL and testbench
===============================

Name: sfp_norm_seq

Overview:
- Parametrised, sequential successor to the single-row SFP normalizer that sits between psum memory (pmem) read data and pmem write-back in fullchip.
- Accepts one row of col signed partial sums through a valid/ready handshake and computes S = sum of |x_i|.
- Each lane is divided by D = (S >> SHIFT) + 1 using per-lane iterative restoring dividers; the normalized row is returned through an output valid/ready handshake.
- Adds bypass and sum-only modes, back-pressure, and configurable width, lane count and shift.

Parameters:
- col, 8, number of lanes per row.
- bw_psum, 20, signed width of each lane.
- SHIFT, 7, right-shift applied to S before the +1.
- SUM_W, bw_psum+$clog2(col), width of S (derived; do not override).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  0=normalize, 1=bypass, 2=sum-only, 3=reserved (treated as bypass); sampled on input accept.
- in_valid  in  1  row valid.
- in_ready  out  1  block can accept a row.
- in_data  in  col*bw_psum  lane i at bits [bw_psum*(i+1)-1 : bw_psum*i], signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  col*bw_psum  result row, same packing as in_data.
- out_sum  out  SUM_W  S of the current row; valid with out_valid in all modes.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; out_valid=0; out_data=0; out_sum=0; busy=0. in_ready=1 after reset deassertion.
- Reset asserted mid-operation: the row in flight is discarded and no partial output is produced.
- States: IDLE, ACC, DIV, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register in_data and mode.
  - mode 1/3 -> DONE. out_data = in_data, out_sum = S.
  - otherwise -> ACC.
- ACC (1 cycle):
  - |x| is computed unsigned in bw_psum bits, so the most negative value maps to 2^(bw_psum-1) without overflow.
  - S is the registered sum of all |x| in SUM_W bits.
  - D = (S >> SHIFT) + 1 in (SUM_W-SHIFT+1) bits, so D >= 1 always.
  - mode 2 -> DONE (out_data = 0, out_sum = S). mode 0 -> DIV.
- DIV: exactly bw_psum cycles.
  - All lanes run a restoring divider in parallel, one quotient bit per cycle, MSB first.
  - q = |x| / D, truncated.
  - Result = x<0 ? -q : q, i.e. truncation toward zero, matching Verilog $signed division.
  - The result always fits in bw_psum bits.
  - -> DONE.
- DONE: out_valid=1.
  - out_data and out_sum hold stable while out_ready=0.
  - On out_ready, leave DONE.
  - in_ready = out_ready in this state: a new row may be accepted in the same cycle as the output handshake, entering ACC or DONE directly with no IDLE bubble.
  - If out_ready=1 and in_valid=0 -> IDLE.
- Latency from the accept edge to out_valid:
  - normalize: bw_psum+2 cycles.
  - sum-only: 2 cycles.
  - bypass: 1 cycle.
- in_valid while not ready: ignored; the source must hold its data.
- mode changes outside the accept cycle have no effect.

Decomposition:
- Package sfp_pkg holds:
  - mode encodings (SFP_NORM, SFP_BYP, SFP_SUM);
  - state encoding;
  - a function for the abs-sum width;
  - the default SHIFT constant.
- Sub-module sfp_div_serial: one lane.
  - Inputs: start, signed dividend, unsigned divisor.
  - Outputs: signed quotient, done.
  - bw_psum-cycle restoring division with sign correction.
  - col instances in a generate loop.

Test Plan:
- All lanes +128, mode 0 -> S=1024, D=9, every lane 14, out_sum=1024; out_valid exactly 22 cycles after accept (bw_psum=20).
- Lane0=-1000, other lanes 0, mode 0 -> S=1000, D=8, lane0=-125 (0xFFF83), others 0.
- Lane0=-524288, others 0 -> S=524288, D=4097, lane0=-127. Also all-zero row -> D=1, outputs 0, out_sum=0.
- mode 1 with random row -> out_data==in_data 1 cycle after accept. mode 2 -> out_data=0, out_sum correct 2 cycles after accept.
- Back-pressure:
  - out_ready=0 for 10 cycles in DONE -> out_data and out_sum stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> next row accepted in the same cycle and the new result is correct.
- reset low during DIV cycle 5 -> out_valid=0, state IDLE, in_ready=1 after release; the next row computes correctly.

Source files
------------

// File: rtl/sfp_norm_seq_pkg.sv
// Shared encodings and helpers for the sequential SFP row normalizer.
package sfp_pkg;

    typedef enum logic [1:0] {
        SFP_NORM = 2'd0,
        SFP_BYP  = 2'd1,
        SFP_SUM  = 2'd2,
        SFP_RSV  = 2'd3
    } sfp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } sfp_state_e;

    localparam int unsigned SFP_SHIFT_DEF = 7;

    // Width that holds the sum of n magnitudes of w-bit signed values.
    function automatic int unsigned sfp_sum_w(input int unsigned w, input int unsigned n);
        return w + $clog2(n);
    endfunction

    // The reserved encoding behaves exactly like bypass.
    function automatic logic sfp_is_bypass(input logic [1:0] m);
        return (m == SFP_BYP) || (m == SFP_RSV);
    endfunction

endpackage

// File: rtl/sfp_div_serial.sv
// One lane: restoring divider, one quotient bit per cycle, MSB first, truncation toward zero.
module sfp_div_serial
    import sfp_pkg::*;
#(
    parameter int unsigned W  = 20,
    parameter int unsigned DW = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic [DW-1:0]       divisor,
    output logic signed [W-1:0] quot_c,
    output logic                done_c
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic          active_q;
    logic          neg_q;
    logic [W-1:0]  dvd_q;
    logic [W-1:0]  quo_q;
    logic [DW-1:0] dsr_q;
    logic [DW-1:0] rem_q;
    logic [CW-1:0] cnt_q;

    logic [DW:0]   trial_c;
    logic          fits_c;
    logic [DW-1:0] rem_d;
    logic [W-1:0]  quo_d;
    logic [W-1:0]  mag_c;

    // One restoring step; quot_c already includes this cycle's bit so the final value can be captured on the last edge.
    always_comb begin
        trial_c = {rem_q, dvd_q[W-1]};
        fits_c  = (trial_c >= {1'b0, dsr_q});
        rem_d   = fits_c ? DW'(trial_c - {1'b0, dsr_q}) : DW'(trial_c);
        quo_d   = {quo_q[W-2:0], fits_c};
        quot_c  = neg_q ? W'(-quo_d) : quo_d;
        done_c  = active_q && (cnt_q == CW'(W - 1));
        mag_c   = dividend[W-1] ? W'(-dividend) : W'(dividend);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            neg_q    <= 1'b0;
            dvd_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            neg_q    <= dividend[W-1];
            dvd_q    <= mag_c;
            quo_q    <= '0;
            dsr_q    <= divisor;
            rem_q    <= '0;
            cnt_q    <= '0;
        end else if (active_q) begin
            dvd_q <= dvd_q << 1;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_c) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sfp_norm_seq.sv
// Sequential SFP normalizer: divides each lane of a psum row by (sum|x| >> SHIFT) + 1.
module sfp_norm_seq
    import sfp_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned bw_psum = 20,
    parameter int unsigned SHIFT   = SFP_SHIFT_DEF,
    parameter int unsigned SUM_W   = sfp_sum_w(bw_psum, col)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*bw_psum-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*bw_psum-1:0]   out_data,
    output logic [SUM_W-1:0]         out_sum,
    output logic                     busy
);

    localparam int unsigned ROW_W = col * bw_psum;
    localparam int unsigned DIV_W = SUM_W - SHIFT + 1;

    sfp_state_e         state_q, state_d;
    logic [1:0]         mode_q;
    logic [ROW_W-1:0]   row_q;
    logic [SUM_W-1:0]   s_q;

    logic               accept_c;
    logic               div_start_c;
    logic               sum_done_c;
    logic               div_done_c;
    logic [SUM_W-1:0]   sum_c;
    logic [bw_psum-1:0] lane_c;
    logic [bw_psum-1:0] mag_c;
    logic [DIV_W-1:0]   div_d_c;
    logic [ROW_W-1:0]   quot_all_c;
    logic [col-1:0]     lane_done_c;

    // Magnitudes are unsigned in bw_psum bits so the most negative lane does not overflow.
    always_comb begin
        sum_c  = '0;
        lane_c = '0;
        mag_c  = '0;
        for (int i = 0; i < int'(col); i++) begin
            lane_c = in_data[i*bw_psum +: bw_psum];
            mag_c  = lane_c[bw_psum-1] ? bw_psum'(-lane_c) : lane_c;
            sum_c  = sum_c + SUM_W'(mag_c);
        end
    end

    assign div_d_c    = DIV_W'(s_q >> SHIFT) + DIV_W'(1);
    assign div_done_c = &lane_done_c;
    assign busy       = (state_q != ST_IDLE);

    for (genvar g = 0; g < int'(col); g++) begin : g_lane
        sfp_div_serial #(
            .W  (bw_psum),
            .DW (DIV_W)
        ) u_div (
            .clk      (clk),
            .reset    (reset),
            .start    (div_start_c),
            .dividend (row_q[g*bw_psum +: bw_psum]),
            .divisor  (div_d_c),
            .quot_c   (quot_all_c[g*bw_psum +: bw_psum]),
            .done_c   (lane_done_c[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE accepts a new row in the same cycle as the output handshake, skipping IDLE.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        div_start_c = 1'b0;
        sum_done_c  = 1'b0;
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = sfp_is_bypass(mode) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (mode_q == SFP_SUM) begin
                    sum_done_c = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    div_start_c = 1'b1;
                    state_d     = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept_c = 1'b1;
                        state_d  = sfp_is_bypass(mode) ? ST_DONE : ST_ACC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row capture and result registers; results only change on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= '0;
            row_q     <= '0;
            s_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sum   <= '0;
        end else begin
            if (accept_c) begin
                row_q  <= in_data;
                mode_q <= mode;
                s_q    <= sum_c;
                if (sfp_is_bypass(mode)) begin
                    out_data  <= in_data;
                    out_sum   <= sum_c;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if ((state_q == ST_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end

            if (sum_done_c) begin
                out_data  <= '0;
                out_sum   <= s_q;
                out_valid <= 1'b1;
            end

            if ((state_q == ST_DIV) && div_done_c) begin
                out_data  <= quot_all_c;
                out_sum   <= s_q;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sfp_norm_seq.sv
// Directed scoreboard bench for sfp_norm_seq with an independent division model.
module tb_sfp_norm_seq;

    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 20;
    localparam int unsigned SHIFT = 7;
    localparam int unsigned SUM_W = BW + $clog2(COL);
    localparam int unsigned ROW_W = COL * BW;

    logic             clk;
    logic             reset;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic [SUM_W-1:0] out_sum;
    logic             busy;

    int tests = 0;
    int fails = 0;

    logic [ROW_W-1:0] exp_d_q[$];
    logic [SUM_W-1:0] exp_s_q[$];

    sfp_norm_seq #(
        .col     (COL),
        .bw_psum (BW),
        .SHIFT   (SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] model_sum(input logic [ROW_W-1:0] row);
        longint acc = 0;
        logic signed [BW-1:0] l;
        for (int i = 0; i < int'(COL); i++) begin
            l = row[i*BW +: BW];
            acc += (l < 0) ? -longint'(l) : longint'(l);
        end
        return SUM_W'(acc);
    endfunction

    function automatic logic [ROW_W-1:0] model_data(input logic [ROW_W-1:0] row, input logic [1:0] m);
        logic [ROW_W-1:0] res = '0;
        logic signed [BW-1:0] l;
        longint d, q;
        if (m == 2'd1 || m == 2'd3) return row;
        if (m == 2'd2) return '0;
        d = longint'(model_sum(row) >> SHIFT) + 1;
        for (int i = 0; i < int'(COL); i++) begin
            l = row[i*BW +: BW];
            q = longint'(l) / d;
            res[i*BW +: BW] = BW'(q);
        end
        return res;
    endfunction

    // Offer a row until accepted, then scramble inputs to prove they were captured.
    task automatic send(input logic [ROW_W-1:0] row, input logic [1:0] m);
        logic r = 1'b0;
        int n = 0;
        in_data  = row;
        mode     = m;
        in_valid = 1'b1;
        while (!r && n < 100) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_data  = ~row;
        mode     = ~m;
        chk("accept", ROW_W'(r), ROW_W'(1));
        exp_d_q.push_back(model_data(row, m));
        exp_s_q.push_back(model_sum(row));
    endtask

    // Wait for out_valid (accept edge counts as cycle 1), check latency and scoreboard entry.
    task automatic expect_out(input int lat, input bit consume);
        int n = 1;
        logic [ROW_W-1:0] ed;
        logic [SUM_W-1:0] es;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid_timeout", ROW_W'(out_valid), ROW_W'(1));
        chk("latency", ROW_W'(n), ROW_W'(lat));
        if (exp_d_q.size() > 0) begin
            ed = exp_d_q.pop_front();
            es = exp_s_q.pop_front();
            chk("out_data", out_data, ed);
            chk("out_sum", ROW_W'(out_sum), ROW_W'(es));
        end else begin
            chk("scoreboard_empty", ROW_W'(0), ROW_W'(1));
        end
        if (consume) begin
            @(posedge clk);
            #1;
            chk("out_valid_drop", ROW_W'(out_valid), ROW_W'(0));
        end
    endtask

    function automatic logic [ROW_W-1:0] fill(input logic [BW-1:0] v);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < int'(COL); i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row(input int unsigned range);
        logic [ROW_W-1:0] r;
        int v;
        for (int i = 0; i < int'(COL); i++) begin
            v = int'($urandom_range(2 * range, 0)) - int'(range);
            r[i*BW +: BW] = BW'(v);
        end
        return r;
    endfunction

    initial begin
        logic [ROW_W-1:0] row_a, row_b, ea, r;
        logic [SUM_W-1:0] sa;

        reset     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", ROW_W'(out_valid), ROW_W'(0));
        chk("rst_out_data", out_data, ROW_W'(0));
        chk("rst_out_sum", ROW_W'(out_sum), ROW_W'(0));
        chk("rst_busy", ROW_W'(busy), ROW_W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", ROW_W'(in_ready), ROW_W'(1));

        // All lanes +128: S=1024, D=9, every lane 14.
        row_a = fill(BW'(128));
        send(row_a, 2'd0);
        chk("busy_acc", ROW_W'(busy), ROW_W'(1));
        expect_out(22, 1'b1);
        chk("lane_all14", out_data, fill(BW'(14)));
        chk("sum_1024", ROW_W'(out_sum), ROW_W'(1024));

        // Lane0=-1000: S=1000, D=8, lane0=-125.
        row_a = '0;
        row_a[BW-1:0] = BW'(-1000);
        send(row_a, 2'd0);
        expect_out(22, 1'b1);
        chk("lane0_m125", ROW_W'(out_data), ROW_W'(20'hFFF83));

        // Most negative lane: S=524288, D=4097, lane0=-127.
        row_a = '0;
        row_a[BW-1:0] = BW'(20'h80000);
        send(row_a, 2'd0);
        expect_out(22, 1'b1);
        r = '0;
        r[BW-1:0] = BW'(-127);
        chk("lane0_m127", out_data, r);

        // All-zero row: D=1, zero results.
        send('0, 2'd0);
        expect_out(22, 1'b1);

        // Bypass, reserved, sum-only.
        send(rand_row(500000), 2'd1);
        expect_out(1, 1'b1);
        send(rand_row(500000), 2'd3);
        expect_out(1, 1'b1);
        send(rand_row(500000), 2'd2);
        expect_out(2, 1'b1);

        // Random normalize rows across small and large ranges.
        for (int k = 0; k < 4; k++) begin
            send(rand_row((k % 2 == 0) ? 300 : 500000), 2'd0);
            expect_out(22, 1'b1);
        end

        // Back-pressure for 10 cycles, then back-to-back accept on the output handshake.
        out_ready = 1'b0;
        row_a = rand_row(200000);
        ea = model_data(row_a, 2'd0);
        sa = model_sum(row_a);
        send(row_a, 2'd0);
        expect_out(22, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", ROW_W'(out_valid), ROW_W'(1));
            chk("bp_data", out_data, ea);
            chk("bp_sum", ROW_W'(out_sum), ROW_W'(sa));
            chk("bp_in_ready", ROW_W'(in_ready), ROW_W'(0));
        end
        out_ready = 1'b1;
        row_b = rand_row(4000);
        send(row_b, 2'd0);
        chk("b2b_valid_low", ROW_W'(out_valid), ROW_W'(0));
        chk("b2b_busy", ROW_W'(busy), ROW_W'(1));
        expect_out(22, 1'b1);

        // Reset during DIV cycle 5 discards the row.
        send(rand_row(100000), 2'd0);
        repeat (5) @(posedge clk);
        #2;
        chk("div_busy", ROW_W'(busy), ROW_W'(1));
        chk("div_no_valid", ROW_W'(out_valid), ROW_W'(0));
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", ROW_W'(out_valid), ROW_W'(0));
        chk("mid_rst_busy", ROW_W'(busy), ROW_W'(0));
        chk("mid_rst_in_ready", ROW_W'(in_ready), ROW_W'(1));
        exp_d_q.delete();
        exp_s_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", ROW_W'(in_ready), ROW_W'(1));
        chk("post_rst_valid", ROW_W'(out_valid), ROW_W'(0));
        send(rand_row(50000), 2'd0);
        expect_out(22, 1'b1);

        chk("scoreboard_drained", ROW_W'(exp_d_q.size()), ROW_W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
